p7_timer: RTL and testbench
===========================

Name: p7_timer

Overview:
Memory-mapped countdown timer on the p7 system bridge. It responds to the CPU's load/store traffic, the other end of the CPU-to-device bus, and raises an interrupt request into CP0.
- Three word registers (CTRL, PRESET, COUNT), addressed by word offset.
- Decrements COUNT once per clock while enabled.
- Two modes: one-shot and auto-reload.

Parameters:
- WIDTH, 32, data/count register width.
- IRQ_HOLD, 1, 1 keeps irq asserted until software acknowledges it; 0 pulses irq for one cycle.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- sel  input  1  bridge device select for this timer
- we  input  1  write strobe, valid only with sel
- addr  input  2  word offset: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
- wdata  input  WIDTH  store data from CPU
- rdata  output  WIDTH  load data to CPU, combinational from addr
- irq  output  1  interrupt request to CP0 (HWInt)

Behaviour:
- Reset: one clock edge with rst=1 clears CTRL, PRESET, COUNT and irq, and forces state IDLE. rdata=0 while addr selects a cleared register. rst asserted mid-count aborts the count with no irq.
- CTRL bits:
  - [0] EN: counter enable.
  - [2:1] MODE: 00 one-shot, 01 auto-reload, others treated as 00.
  - [3] IM: interrupt mask, 1 = enabled.
  - [31:4] read as 0; writes to them are ignored.
- Writes:
  - Take effect at the clock edge where sel&we=1.
  - COUNT is read-only; writes to it are ignored. Writes to offset 3 are ignored.
  - Writing CTRL with EN=0 also clears a pending irq (software ack).
- Reads: no side effects. Reads of offset 3 return 0.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT<=PRESET, then -> CNT. One cycle.
  - CNT: if EN=0 -> IDLE, with COUNT holding its value. Else if COUNT>1, COUNT<=COUNT-1. Else (COUNT<=1), COUNT<=0 and -> INT.
  - INT: raise irq if IM=1.
    - One-shot: clear EN in CTRL, then -> IDLE.
    - Auto-reload: -> LOAD.
- Latency: irq rises exactly PRESET+1 cycles after the edge that leaves LOAD. With PRESET=N≥1, irq is visible N+2 cycles after EN is written.
- PRESET=0: behaves like PRESET=1. Never underflows; no wrap to all-ones.
- irq:
  - IRQ_HOLD=1: stays high until CTRL is written with EN=0 or IM=0.
  - IRQ_HOLD=0: high for the single cycle after INT.
- Write to PRESET during CNT: does not affect the current COUNT; used at the next LOAD.
- Simultaneous CTRL write and INT in the same cycle: the CPU write wins for the EN bit. irq is still set from the INT event unless the write sets IM=0.

Optional Feature:
- Macro: P7_TIMER_PRESCALE_EN.
- Defined: offset 3 becomes a PRESCALE register (16 bits, upper bits read 0). COUNT decrements once every PRESCALE+1 cycles in CNT. The prescaler clears at LOAD and at reset.
- Undefined: offset 3 is reserved, as specified above, and COUNT decrements every cycle.

Decomposition:
- Shared package p7_dev_pkg:
  - Register offset constants TC_CTRL=2'd0, TC_PRESET=2'd1, TC_COUNT=2'd2, TC_PRE=2'd3.
  - Mode constants.
  - Timer state encoding.
  - CTRL bit-position constants, reused by the bridge address decoder.
- Sub-module: p7_timer_regs (register file and read mux), leaving the FSM and counter in p7_timer.

Test Plan:
- Reset then read all offsets -> rdata=0, irq=0. Asserting rst mid-count with COUNT=5 -> COUNT=0 and state IDLE on the next edge.
- PRESET=3, CTRL=0x9 (EN, one-shot, IM) -> COUNT sequence 3,2,1,0. irq rises at cycle 5 after the write. EN reads 0 afterward, and there is no second irq.
- PRESET=2, CTRL=0xB (auto-reload) -> irq every 4 cycles (IRQ_HOLD=0 build). COUNT cycles 2,1,0,2,1,0.
- Pending irq (IRQ_HOLD=1), write CTRL=0x0 -> irq clears the next cycle. IM=0 with count expiry -> irq never asserts, but state still passes through INT.
- Write COUNT=0x55 and offset 3 (macro undefined) -> no register changes; offset 3 reads 0. PRESET=0 -> behaves as PRESET=1.
- With P7_TIMER_PRESCALE_EN, PRESCALE=1, PRESET=2 -> COUNT decrements every 2 cycles. irq 6 cycles after LOAD.

Source files
------------

// File: rtl/p7_dev_pkg.sv
// Shared definitions for p7 bridge devices: timer register offsets, CTRL bit
// positions, mode codes and the timer state encoding.
package p7_dev_pkg;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;
  localparam logic [1:0] TC_PRE    = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;
  localparam int CTRL_W        = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam int PRESCALE_W = 16;

  typedef enum logic [1:0] {
    TS_IDLE = 2'd0,
    TS_LOAD = 2'd1,
    TS_CNT  = 2'd2,
    TS_INT  = 2'd3
  } timer_state_e;

  // Field order matches the CTRL bit positions above.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } timer_ctrl_t;

  // Only 01 reloads; the two unused codes fall back to one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/p7_timer_if.sv
// CPU-side bridge port of the p7 timer: select, write strobe, word offset and
// data in both directions.
interface p7_timer_if #(
  parameter int WIDTH = 32
);
  logic             sel;
  logic             we;
  logic [1:0]       addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;

  modport master (output sel, we, addr, wdata, input rdata);
  modport slave  (input sel, we, addr, wdata, output rdata);
endinterface

// File: rtl/p7_timer_regs.sv
// Timer register file and combinational read mux. Defining P7_TIMER_PRESCALE_EN
// turns offset 3 into a 16-bit PRESCALE register.
module p7_timer_regs
  import p7_dev_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel,
  input  logic                  we,
  input  logic [1:0]            addr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH-1:0]      count,
  input  logic                  clear_en,
  output timer_ctrl_t           ctrl_eff,
  output logic                  ctrl_wr,
  output logic [WIDTH-1:0]      preset,
  output logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      rdata
);

  timer_ctrl_t ctrl;
  logic        wr;

  assign wr      = sel & we;
  assign ctrl_wr = wr && (addr == TC_CTRL);
  // The FSM decides on the value CTRL is about to take, so a CPU write wins.
  assign ctrl_eff = ctrl_wr ? timer_ctrl_t'(wdata[CTRL_W-1:0]) : ctrl;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl   <= '0;
      preset <= '0;
    end else begin
      if (ctrl_wr)        ctrl    <= timer_ctrl_t'(wdata[CTRL_W-1:0]);
      else if (clear_en)  ctrl.en <= 1'b0;
      if (wr && (addr == TC_PRESET)) preset <= wdata;
    end
  end

`ifdef P7_TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale_q;

  always_ff @(posedge clk) begin
    if (rst)                       prescale_q <= '0;
    else if (wr && addr == TC_PRE) prescale_q <= wdata[PRESCALE_W-1:0];
  end

  assign prescale = prescale_q;
`else
  assign prescale = '0;
`endif

  // NOTE: rdata gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata = '0;
    unique case (addr)
      TC_CTRL:   rdata[CTRL_W-1:0] = ctrl;
      TC_PRESET: rdata = preset;
      TC_COUNT:  rdata = count;
      TC_PRE: begin
`ifdef P7_TIMER_PRESCALE_EN
        rdata[PRESCALE_W-1:0] = prescale_q;
`endif
      end
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/p7_timer.sv
// p7 countdown timer: FSM, COUNT register and irq generation around the
// register file. P7_TIMER_PRESCALE_EN (see p7_timer_regs) enables prescaling.
module p7_timer
  import p7_dev_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit IRQ_HOLD = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  p7_timer_if.slave  bus,
  output logic       irq
);

  timer_state_e          state, state_nxt;
  logic [WIDTH-1:0]      count, count_nxt;
  logic [PRESCALE_W-1:0] pre_cnt, pre_nxt;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      preset;
  timer_ctrl_t           ctrl_eff;
  logic                  ctrl_wr, clear_en, irq_set, irq_ack, irq_nxt;

  p7_timer_regs #(.WIDTH(WIDTH)) u_regs (
    .clk      (clk),
    .rst      (rst),
    .sel      (bus.sel),
    .we       (bus.we),
    .addr     (bus.addr),
    .wdata    (bus.wdata),
    .count    (count),
    .clear_en (clear_en),
    .ctrl_eff (ctrl_eff),
    .ctrl_wr  (ctrl_wr),
    .preset   (preset),
    .prescale (prescale),
    .rdata    (bus.rdata)
  );

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    pre_nxt   = pre_cnt;
    clear_en  = 1'b0;
    unique case (state)
      TS_IDLE: if (ctrl_eff.en) state_nxt = TS_LOAD;
      TS_LOAD: begin
        count_nxt = preset;
        pre_nxt   = '0;
        state_nxt = TS_CNT;
      end
      TS_CNT: begin
        if (!ctrl_eff.en) begin
          state_nxt = TS_IDLE;
        end else if (pre_cnt == prescale) begin
          pre_nxt = '0;
          // Stopping at 1 rather than 0 makes PRESET=0 expire like PRESET=1.
          if (count > WIDTH'(1)) begin
            count_nxt = count - WIDTH'(1);
          end else begin
            count_nxt = '0;
            state_nxt = TS_INT;
          end
        end else begin
          pre_nxt = pre_cnt + PRESCALE_W'(1);
        end
      end
      TS_INT: begin
        if (is_reload(ctrl_eff.mode)) begin
          state_nxt = TS_LOAD;
        end else begin
          clear_en  = 1'b1;
          state_nxt = TS_IDLE;
        end
      end
      default: state_nxt = TS_IDLE;
    endcase
  end

  // Expiry beats a same-cycle acknowledge unless that write masks the irq.
  assign irq_set = (state == TS_INT) && ctrl_eff.im;
  assign irq_ack = ctrl_wr && (!ctrl_eff.en || !ctrl_eff.im);
  assign irq_nxt = IRQ_HOLD ? (irq_set | (irq & ~irq_ack)) : irq_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TS_IDLE;
      count   <= '0;
      pre_cnt <= '0;
      irq     <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      pre_cnt <= pre_nxt;
      irq     <= irq_nxt;
    end
  end

endmodule

// File: tb/tb_p7_timer.sv
// Bench for p7_timer: a held-irq and a pulsed-irq instance share one stimulus
// stream and are compared every cycle against a behavioural model.
module tb_p7_timer;
  import p7_dev_pkg::*;

  localparam int WIDTH = 32;
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_CNT = 2, PH_INT = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sel = 1'b0;
  logic             we = 1'b0;
  logic [1:0]       addr = 2'd0;
  logic [WIDTH-1:0] wdata = '0;
  logic             irq_h, irq_p;

  int total = 0;
  int bad = 0;
  bit cmp_on = 1'b0;

  p7_timer_if #(.WIDTH(WIDTH)) bus_h ();
  p7_timer_if #(.WIDTH(WIDTH)) bus_p ();

  assign bus_h.sel = sel;   assign bus_p.sel = sel;
  assign bus_h.we = we;     assign bus_p.we = we;
  assign bus_h.addr = addr; assign bus_p.addr = addr;
  assign bus_h.wdata = wdata; assign bus_p.wdata = wdata;

  p7_timer #(.WIDTH(WIDTH), .IRQ_HOLD(1'b1)) dut_h (
    .clk(clk), .rst(rst), .bus(bus_h), .irq(irq_h));
  p7_timer #(.WIDTH(WIDTH), .IRQ_HOLD(1'b0)) dut_p (
    .clk(clk), .rst(rst), .bus(bus_p), .irq(irq_p));

  always #5 clk = ~clk;

  // Behavioural model state.
  logic        m_en, m_im;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count;
  logic [15:0] m_prescale;
  int          m_phase, m_pre;
  logic        m_irq_h, m_irq_p;

  initial begin
    m_en = 0; m_im = 0; m_mode = 0; m_preset = 0; m_count = 0;
    m_prescale = 0; m_phase = PH_IDLE; m_pre = 0; m_irq_h = 0; m_irq_p = 0;
  end

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0: return {28'd0, m_im, m_mode, m_en};
      2'd1: return m_preset;
      2'd2: return m_count;
      default: begin
`ifdef P7_TIMER_PRESCALE_EN
        return {16'd0, m_prescale};
`else
        return 32'd0;
`endif
      end
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic wr_c, wctrl, en_e, im_e, clr_en;
    logic [1:0] mode_e;
    int nph, npre;
    logic [31:0] ncnt;
    if (rst) begin
      m_en = 0; m_im = 0; m_mode = 0; m_preset = 0; m_count = 0;
      m_prescale = 0; m_phase = PH_IDLE; m_pre = 0; m_irq_h = 0; m_irq_p = 0;
    end else begin
      wr_c   = sel && we;
      wctrl  = wr_c && (addr == 2'd0);
      en_e   = wctrl ? wdata[0] : m_en;
      im_e   = wctrl ? wdata[3] : m_im;
      mode_e = wctrl ? wdata[2:1] : m_mode;
      nph = m_phase; ncnt = m_count; npre = m_pre; clr_en = 0;
      case (m_phase)
        PH_IDLE: if (en_e) nph = PH_LOAD;
        PH_LOAD: begin ncnt = m_preset; npre = 0; nph = PH_CNT; end
        PH_CNT: begin
          if (!en_e) nph = PH_IDLE;
          else if (m_pre == int'(m_prescale)) begin
            npre = 0;
            if (m_count > 1) ncnt = m_count - 1;
            else begin ncnt = 0; nph = PH_INT; end
          end else npre = m_pre + 1;
        end
        default: begin
          if (mode_e == 2'b01) nph = PH_LOAD;
          else begin clr_en = 1; nph = PH_IDLE; end
        end
      endcase
      m_irq_p = (m_phase == PH_INT) && im_e;
      if ((m_phase == PH_INT) && im_e) m_irq_h = 1;
      else if (wctrl && (!wdata[0] || !wdata[3])) m_irq_h = 0;
      if (wctrl) begin m_en = wdata[0]; m_mode = wdata[2:1]; m_im = wdata[3]; end
      else if (clr_en) m_en = 0;
      if (wr_c && addr == 2'd1) m_preset = wdata;
`ifdef P7_TIMER_PRESCALE_EN
      if (wr_c && addr == 2'd3) m_prescale = wdata[15:0];
`endif
      m_phase = nph; m_count = ncnt; m_pre = npre;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check("cmp_rdata_h", bus_h.rdata, model_read(addr));
      check("cmp_rdata_p", bus_p.rdata, model_read(addr));
      check("cmp_irq_h", {31'd0, irq_h}, {31'd0, m_irq_h});
      check("cmp_irq_p", {31'd0, irq_p}, {31'd0, m_irq_p});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1; we = 1; addr = a; wdata = d;
    tick();
    sel = 0; we = 0;
  endtask

  task automatic peek(input logic [1:0] a, input string name, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, bus_h.rdata, exp);
  endtask

  initial begin
    tick();
    rst = 0;
    cmp_on = 1;

    // Reset state.
    for (int a = 0; a < 4; a++) peek(a[1:0], "rst_read", 32'd0);
    check("rst_irq", {31'd0, irq_h}, 32'd0);

    // One-shot, PRESET=3: COUNT 3,2,1,0 then irq five cycles after the write.
    wr(TC_PRESET, 32'd3);
    wr(TC_CTRL, 32'h9);
    peek(TC_COUNT, "os_cnt_load", 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      peek(TC_COUNT, "os_cnt", 32'(4 - k));
    end
    check("os_irq_early", {31'd0, irq_h}, 32'd0);
    tick();
    check("os_irq_h", {31'd0, irq_h}, 32'd1);
    check("os_irq_p", {31'd0, irq_p}, 32'd1);
    peek(TC_CTRL, "os_en_cleared", 32'h8);
    tick();
    check("os_pulse_end", {31'd0, irq_p}, 32'd0);
    check("os_hold", {31'd0, irq_h}, 32'd1);
    repeat (6) tick();
    check("os_no_second", {31'd0, irq_p}, 32'd0);
    wr(TC_CTRL, 32'h0);
    check("ack_clears", {31'd0, irq_h}, 32'd0);

    // Auto-reload, PRESET=2: irq every 4 cycles.
    wr(TC_PRESET, 32'd2);
    wr(TC_CTRL, 32'hB);
    for (int k = 1; k <= 13; k++) begin
      tick();
      check("ar_irq_p", {31'd0, irq_p}, (k % 4 == 0) ? 32'd1 : 32'd0);
      peek(TC_COUNT, "ar_cnt", (k % 4 == 1) ? 32'd2 : (k % 4 == 2) ? 32'd1 : 32'd0);
    end
    wr(TC_CTRL, 32'h0);
    check("ar_ack", {31'd0, irq_h}, 32'd0);
    peek(TC_COUNT, "ar_stop_holds", 32'd2);

    // IM=0: expiry passes through INT (EN clears) without any irq.
    wr(TC_PRESET, 32'd1);
    wr(TC_CTRL, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("im0_irq", {31'd0, irq_h}, 32'd0);
    end
    peek(TC_CTRL, "im0_en_cleared", 32'h0);

    // COUNT is read-only; offset 3 ignored unless prescaling is built in.
    wr(TC_COUNT, 32'h55);
    peek(TC_COUNT, "count_ro", 32'd0);
    wr(TC_PRE, 32'hABCD);
`ifdef P7_TIMER_PRESCALE_EN
    peek(TC_PRE, "pre_read", 32'h0000ABCD);
    wr(TC_PRE, 32'h0);
`else
    peek(TC_PRE, "rsvd_read", 32'd0);
`endif
    peek(TC_PRESET, "preset_kept", 32'd1);

    // PRESET=0 expires like PRESET=1: irq three cycles after the write.
    wr(TC_PRESET, 32'd0);
    wr(TC_CTRL, 32'h9);
    tick(); tick();
    check("p0_irq_early", {31'd0, irq_h}, 32'd0);
    tick();
    check("p0_irq", {31'd0, irq_h}, 32'd1);
    wr(TC_CTRL, 32'h0);

    // Reset mid-count.
    wr(TC_PRESET, 32'd5);
    wr(TC_CTRL, 32'h9);
    tick();
    peek(TC_COUNT, "mid_cnt", 32'd5);
    rst = 1;
    tick();
    rst = 0;
    peek(TC_COUNT, "mid_rst_cnt", 32'd0);
    peek(TC_CTRL, "mid_rst_ctrl", 32'd0);
    repeat (8) tick();
    check("mid_rst_irq", {31'd0, irq_h}, 32'd0);
    peek(TC_COUNT, "mid_rst_idle", 32'd0);

`ifdef P7_TIMER_PRESCALE_EN
    // PRESCALE=1, PRESET=2: COUNT steps every 2 cycles, irq 6 cycles after LOAD.
    wr(TC_PRE, 32'd1);
    wr(TC_PRESET, 32'd2);
    wr(TC_CTRL, 32'h9);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("ps_irq", {31'd0, irq_h}, (k == 6) ? 32'd1 : 32'd0);
      peek(TC_COUNT, "ps_cnt", (k <= 2) ? 32'd2 : (k <= 4) ? 32'd1 : 32'd0);
    end
    wr(TC_CTRL, 32'h0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(0, 399) == 0);
      sel  = ($urandom_range(0, 3) == 0);
      we   = 1'($urandom_range(0, 1));
      addr = 2'($urandom_range(0, 3));
      case (addr)
        2'd0: begin
          wdata = $urandom;
          if ($urandom_range(0, 3) != 0) wdata[0] = 1'b1;
        end
        2'd1: wdata = $urandom_range(0, 6);
        2'd3: wdata = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 2);
        default: wdata = $urandom;
      endcase
      tick();
    end
    rst = 0; sel = 0; we = 0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
